// File: rtl/pci_mem_target.sv
// pci_mem_target: PCI memory target decoding one BAR window onto a word-wide backend memory port.
module pci_mem_target #(
  parameter int          ADDR_W     = 14,
  parameter logic [31:0] BAR_MASK   = 32'hFFFF_0000,
  parameter int          DISCONNECT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bar_base,
  input  logic [31:0]       ad_i,
  output logic [31:0]       ad_o,
  output logic              ad_oe,
  input  logic [3:0]        cbe_i,
  output logic              par_o,
  output logic              par_oe,
  input  logic              frame_n_i,
  input  logic              irdy_n_i,
  output logic              trdy_n_o,
  output logic              stop_n_o,
  output logic              devsel_n_o,
  output logic              ctl_oe,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata
);
  typedef enum logic [2:0] {IDLE, BUSY, WRITE, READ_TA, READ, BACKOFF} state_t;
  localparam logic [7:0] DLAST = 8'(DISCONNECT - 1);
  localparam bit         DEN   = DISCONNECT != 0;
  state_t state;
  logic frame_prev;
  logic [ADDR_W-1:0] addr;
  logic [7:0] beat;
  logic is_rd, is_wr, hit, addr_phase, done, first_stop;
  assign is_rd      = cbe_i == 4'h6 || cbe_i == 4'hC || cbe_i == 4'hE;
  assign is_wr      = cbe_i == 4'h7 || cbe_i == 4'hF;
  assign hit        = (ad_i & BAR_MASK) == (bar_base & BAR_MASK) && (is_rd || is_wr);
  assign addr_phase = state == IDLE && !frame_n_i && frame_prev && irdy_n_i;
  assign done       = (state == WRITE || state == READ) && !irdy_n_i && !trdy_n_o;
  assign first_stop = DEN && DLAST == 8'd0;
  // Reads look one word ahead on a completion so the next beat is ready without a wait state.
  assign mem_addr   = (state == READ && done) ? addr + ADDR_W'(1) : addr;
  assign mem_we     = state == WRITE && done;
  assign mem_be     = ~cbe_i;
  assign mem_wdata  = ad_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frame_prev <= 1'b1;
      addr       <= '0;
      beat       <= '0;
      ad_o       <= '0;
      ad_oe      <= 1'b0;
      par_o      <= 1'b0;
      par_oe     <= 1'b0;
      trdy_n_o   <= 1'b1;
      stop_n_o   <= 1'b1;
      devsel_n_o <= 1'b1;
      ctl_oe     <= 1'b0;
    end else begin
      frame_prev <= frame_n_i;
      par_o      <= ^{ad_o, cbe_i};
      par_oe     <= ad_oe;
      case (state)
        IDLE: if (addr_phase) begin
          addr <= ad_i[ADDR_W+1:2];
          beat <= '0;
          if (!hit) state <= BUSY;
          else begin
            ctl_oe     <= 1'b1;
            devsel_n_o <= 1'b0;
            if (is_wr) begin
              state    <= WRITE;
              trdy_n_o <= 1'b0;
              stop_n_o <= !first_stop;
            end else state <= READ_TA;
          end
        end
        BUSY: if (frame_n_i && irdy_n_i) state <= IDLE;
        READ_TA: begin
          ad_o     <= mem_rdata;
          ad_oe    <= 1'b1;
          trdy_n_o <= 1'b0;
          stop_n_o <= !first_stop;
          state    <= READ;
        end
        WRITE, READ: begin
          if (done) begin
            addr <= addr + ADDR_W'(1);
            beat <= beat + 8'd1;
          end
          if (state == READ && done) ad_o <= mem_rdata;
          if (frame_n_i && (done || !stop_n_o)) begin
            state      <= BACKOFF;
            trdy_n_o   <= 1'b1;
            stop_n_o   <= 1'b1;
            devsel_n_o <= 1'b1;
            ad_oe      <= 1'b0;
          end else if (done) begin
            if (!stop_n_o) trdy_n_o <= 1'b1;
            else stop_n_o <= !(DEN && beat + 8'd1 == DLAST);
          end
        end
        BACKOFF: begin
          ctl_oe <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pci_mem_target.sv
// tb_pci_mem_target: PCI master model driving two targets (no disconnect / disconnect after 8) against a transaction-level memory model.
module tb_pci_mem_target;
  logic clk = 0;
  logic rst = 0;
  always #15 clk = ~clk;

  logic [31:0] ad = 0;
  logic [3:0]  cbe = 0;
  logic        frame_n = 1, irdy_n = 1;
  logic [31:0] ad_o_x[2], mem_wdata_x[2], mem_rdata_x[2];
  logic        ad_oe_x[2], par_o_x[2], par_oe_x[2], trdy_x[2], stop_x[2], devsel_x[2], ctl_oe_x[2], mem_we_x[2];
  logic [13:0] mem_addr_x[2];
  logic [3:0]  mem_be_x[2];

  logic [31:0] mem [16384];
  logic [31:0] ref_mem [16384];
  logic [13:0] wl_a[$];
  logic [31:0] wl_d[$];
  logic [3:0]  wl_b[$];
  int          wl_s[$];
  int passed = 0, total = 0;

  assign mem_rdata_x[0] = mem[mem_addr_x[0]];
  assign mem_rdata_x[1] = mem[mem_addr_x[1]];

  pci_mem_target #(.DISCONNECT(0)) u0 (
    .clk(clk), .rst(rst), .bar_base(32'h8002_0000), .ad_i(ad), .ad_o(ad_o_x[0]), .ad_oe(ad_oe_x[0]),
    .cbe_i(cbe), .par_o(par_o_x[0]), .par_oe(par_oe_x[0]), .frame_n_i(frame_n), .irdy_n_i(irdy_n),
    .trdy_n_o(trdy_x[0]), .stop_n_o(stop_x[0]), .devsel_n_o(devsel_x[0]), .ctl_oe(ctl_oe_x[0]),
    .mem_addr(mem_addr_x[0]), .mem_rdata(mem_rdata_x[0]), .mem_we(mem_we_x[0]), .mem_be(mem_be_x[0]),
    .mem_wdata(mem_wdata_x[0]));

  pci_mem_target #(.DISCONNECT(8)) u8 (
    .clk(clk), .rst(rst), .bar_base(32'h8003_0000), .ad_i(ad), .ad_o(ad_o_x[1]), .ad_oe(ad_oe_x[1]),
    .cbe_i(cbe), .par_o(par_o_x[1]), .par_oe(par_oe_x[1]), .frame_n_i(frame_n), .irdy_n_i(irdy_n),
    .trdy_n_o(trdy_x[1]), .stop_n_o(stop_x[1]), .devsel_n_o(devsel_x[1]), .ctl_oe(ctl_oe_x[1]),
    .mem_addr(mem_addr_x[1]), .mem_rdata(mem_rdata_x[1]), .mem_we(mem_we_x[1]), .mem_be(mem_be_x[1]),
    .mem_wdata(mem_wdata_x[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    for (int j = 0; j < 4; j++) if (b[j]) o[8*j +: 8] = n[8*j +: 8];
    return o;
  endfunction

  task automatic sample_mem();
    for (int i = 0; i < 2; i++) if (mem_we_x[i]) begin
      mem[mem_addr_x[i]] = merge(mem[mem_addr_x[i]], mem_wdata_x[i], mem_be_x[i]);
      wl_a.push_back(mem_addr_x[i]);
      wl_d.push_back(mem_wdata_x[i]);
      wl_b.push_back(mem_be_x[i]);
      wl_s.push_back(i);
    end
  endtask

  // seq: 0 random data, 1 data=i with all bytes, 2 single 32'hDEADBEEF with all bytes
  task automatic xfer(input bit wr, input logic [31:0] a, input int n, input int wait_at, input int rst_at, input int seq);
    logic [31:0] dat[$];
    logic [3:0]  be[$];
    int s, d, w, k, cyc, waited, exp_beats, wa;
    bit hit, hold, c, fin, stopping, prev_rd, exp_trdy, pexp;
    s = a[31:16] == 16'h8003 ? 1 : 0;
    hit = a[31:16] == 16'h8002 || a[31:16] == 16'h8003;
    d = s ? 8 : 0;
    w = int'(a[15:2]);
    exp_beats = !hit ? 0 : (d != 0 && n > d) ? d : n;
    for (int i = 0; i < n; i++) begin
      dat.push_back(seq == 1 ? 32'(i) : seq == 2 ? 32'hDEADBEEF : $urandom);
      be.push_back(seq != 0 ? 4'hF : wr ? 4'($urandom_range(1, 15)) : 4'($urandom));
    end
    wl_a.delete(); wl_d.delete(); wl_b.delete(); wl_s.delete();
    @(negedge clk);
    frame_n = 0; irdy_n = 1; ad = a;
    if (wr) cbe = (seq != 0 || $urandom_range(0, 1) == 0) ? 4'h7 : 4'hF;
    else case ($urandom_range(0, 2)) 0: cbe = 4'h6; 1: cbe = 4'hC; default: cbe = 4'hE; endcase
    @(negedge clk);
    if (!hit) begin
      frame_n = 1; irdy_n = 0;
      repeat (4) begin
        #1;
        chk("abort_devsel", {31'd0, devsel_x[0] & devsel_x[1]}, 1);
        chk("abort_ctl_oe", {31'd0, ctl_oe_x[0] | ctl_oe_x[1]}, 0);
        sample_mem();
        @(negedge clk);
      end
      irdy_n = 1;
      chk("abort_nwr", wl_a.size(), 0);
      return;
    end
    k = 0; cyc = 0; waited = 0; fin = 0; stopping = 0; prev_rd = 0; pexp = 0;
    while (!fin && cyc < 80) begin
      hold = k == wait_at && waited < 2;
      if (stopping) begin frame_n = 1; irdy_n = 0; end
      else begin
        irdy_n = hold;
        frame_n = (k == n - 1 && !hold) ? 1'b1 : 1'b0;
        if (hold) waited++;
      end
      ad = wr ? dat[k < n ? k : n - 1] : $urandom;
      cbe = ~be[k < n ? k : n - 1];
      #1;
      if (k == rst_at) begin
        rst = 1;
        #1;
        chk("rst_ad_oe", ad_oe_x[s], 0);
        chk("rst_par_oe", par_oe_x[s], 0);
        chk("rst_ctl_oe", ctl_oe_x[s], 0);
        chk("rst_trdy", trdy_x[s], 1);
        chk("rst_devsel", devsel_x[s], 1);
        chk("rst_ad_o", ad_o_x[s], 0);
        frame_n = 1; irdy_n = 1;
        @(negedge clk);
        rst = 0;
        return;
      end
      exp_trdy = (!wr && cyc == 0) || stopping;
      chk("devsel", devsel_x[s], 0);
      chk("ctl_oe", ctl_oe_x[s], 1);
      chk("other_ctl_oe", ctl_oe_x[1-s], 0);
      chk("trdy", trdy_x[s], exp_trdy);
      if (!exp_trdy) chk("stop", stop_x[s], !(d != 0 && k == d - 1));
      else if (stopping) chk("stop_hold", stop_x[s], 0);
      c = !irdy_n && !trdy_x[s];
      chk("mem_we", mem_we_x[s], wr && c);
      wa = (w + k + ((!wr && c) ? 1 : 0)) % 16384;
      chk("mem_addr", mem_addr_x[s], 32'(wa));
      if (!wr && cyc >= 1) begin
        chk("ad_o", ad_o_x[s], ref_mem[(w + k) % 16384]);
        chk("ad_oe", ad_oe_x[s], 1);
      end
      if (prev_rd) begin
        chk("par_oe", par_oe_x[s], 1);
        chk("par", par_o_x[s], pexp);
      end
      pexp = ^{ref_mem[(w + k) % 16384], cbe};
      prev_rd = !wr && cyc >= 1;
      sample_mem();
      if (c) k++;
      if (frame_n && (c || !stop_x[s])) fin = 1;
      else if (c && !stop_x[s]) stopping = 1;
      cyc++;
      @(negedge clk);
    end
    chk("terminated", fin, 1);
    frame_n = 1; irdy_n = 1;
    #1;
    chk("bo_ctl_oe", ctl_oe_x[s], 1);
    chk("bo_trdy", trdy_x[s], 1);
    chk("bo_stop", stop_x[s], 1);
    chk("bo_devsel", devsel_x[s], 1);
    chk("bo_ad_oe", ad_oe_x[s], 0);
    if (!wr) begin
      chk("bo_par_oe", par_oe_x[s], 1);
      chk("bo_par", par_o_x[s], pexp);
    end
    @(negedge clk);
    #1;
    chk("idle_ctl_oe", ctl_oe_x[s], 0);
    chk("idle_par_oe", par_oe_x[s], 0);
    chk("beats", k, exp_beats);
    chk("nwr", wl_a.size(), wr ? exp_beats : 0);
    for (int j = 0; j < exp_beats && wr; j++) begin
      if (j < wl_a.size()) begin
        chk("wr_addr", wl_a[j], 32'((w + j) % 16384));
        chk("wr_data", wl_d[j], dat[j]);
        chk("wr_be", wl_b[j], be[j]);
        chk("wr_dut", wl_s[j], s);
      end
      ref_mem[(w + j) % 16384] = merge(ref_mem[(w + j) % 16384], dat[j], be[j]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #2 rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("por_ctl_oe", ctl_oe_x[i], 0);
      chk("por_ad_oe", ad_oe_x[i], 0);
      chk("por_trdy", trdy_x[i], 1);
      chk("por_stop", stop_x[i], 1);
      chk("por_devsel", devsel_x[i], 1);
      chk("por_ad_o", ad_o_x[i], 0);
      chk("por_par", par_o_x[i], 0);
      chk("por_mem_we", mem_we_x[i], 0);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    xfer(1, 32'h8002_0000, 1, -1, -1, 2);
    xfer(0, 32'h8002_0000, 1, -1, -1, 0);
    chk("deadbeef", mem[0], 32'hDEADBEEF);
    xfer(1, 32'h8002_0000, 16, -1, -1, 1);
    xfer(0, 32'h8002_0000, 16, -1, -1, 0);
    xfer(1, 32'h8003_0000, 16, -1, -1, 1);
    xfer(0, 32'h8003_0000, 16, -1, -1, 0);
    xfer(1, 32'h8003_0040, 8, -1, -1, 0);
    xfer(1, 32'h8002_0100, 10, 4, -1, 0);
    xfer(0, 32'h8002_0100, 10, 3, -1, 0);
    xfer(1, 32'h8004_0000, 4, -1, -1, 0);
    xfer(0, 32'h8004_0000, 4, -1, -1, 0);
    xfer(0, 32'h8002_0100, 4, -1, -1, 0);
    xfer(0, 32'h8002_0000, 12, -1, 5, 0);
    xfer(1, 32'h8002_0200, 3, -1, -1, 0);
    xfer(0, 32'h8002_0200, 3, -1, -1, 0);
    xfer(1, 32'h8002_FFF8, 6, 1, -1, 0);
    xfer(0, 32'h8002_FFF8, 6, -1, -1, 0);
    for (int t = 0; t < 24; t++) begin
      int n;
      logic [31:0] a;
      n = $urandom_range(1, 20);
      a = {16'h8002 | 16'($urandom_range(0, 1)), 2'b00, 14'($urandom_range(0, 16383)), 2'b00};
      if (t % 3 == 0) a[15:2] = 14'h3FF8;
      xfer($urandom_range(0, 1) == 1, a, n, $urandom_range(0, n), -1, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
